// File: rtl/mmio_fifo_pkg.sv
// Shared constants and the status CSR layout for the AFU's MMIO write-to-read FIFO.
package mmio_fifo_pkg;

   localparam int MMIO_FIFO_WIDTH = 64;
   localparam int MMIO_FIFO_DEPTH = 8;
   localparam int MMIO_FIFO_CW    = $clog2(MMIO_FIFO_DEPTH) + 1;

   // Returned by the AFU on a status CSR read.
   typedef struct packed {
      logic                    overflow;
      logic                    underflow;
      logic                    full;
      logic                    empty;
      logic [MMIO_FIFO_CW-1:0] count;
   } t_mmio_fifo_status;

endpackage

// File: rtl/mmio_fifo.sv
// Circular-buffer FIFO with show-ahead head, occupancy count and sticky error flags.
// Pushed by qualified MMIO writes and popped by MMIO reads of the user register.
module mmio_fifo
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_FIFO_WIDTH,
   parameter int DEPTH = MMIO_FIFO_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_en,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_en,
   input  logic             clr_err,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   always_comb begin
      // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
      push_ok = push_en && (!full || pop_en);
      pop_ok  = pop_en && !empty;
      wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
      rd_d    = pop_ok  ? rd_q + PW'(1) : rd_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Set has priority over clear.
      ovf_d = (push_en && full && !pop_en) || (ovf_q && !clr_err);
      udf_d = (pop_en && empty) || (udf_q && !clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_data;
   end

   // Gating by empty hides stale array contents after reset.
   assign head_data = empty ? '0 : mem_q[rd_q];
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

// File: tb/tb_mmio_fifo.sv
// Directed plus randomized bench for mmio_fifo against a queue-based reference model.
module tb_mmio_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             push_en, pop_en, clr_err;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] head_data;
   logic [CW-1:0]    count;
   logic             empty, full, overflow, underflow;

   int checks = 0;
   int errors = 0;

   logic [63:0] q[$];
   bit          m_ovf, m_udf;

   mmio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .push_en(push_en), .push_data(push_data),
      .pop_en(pop_en), .clr_err(clr_err),
      .head_data(head_data), .count(count),
      .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [63:0] exp_head;
      exp_head = (q.size() != 0) ? q[0] : 64'h0;
      chk({tag, ".head"},  head_data, exp_head);
      chk({tag, ".count"}, 64'(count), 64'(q.size()));
      chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
      chk({tag, ".full"},  64'(full),  64'(q.size() == DEPTH));
      chk({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
      chk({tag, ".udf"},   64'(underflow), 64'(m_udf));
   endtask

   // One clock: model the spec's rules on the queue, apply the edge, compare.
   task automatic cyc(input string tag, input bit pu, input logic [63:0] d,
                      input bit po, input bit cl);
      bit f, e;
      push_en = pu; push_data = d; pop_en = po; clr_err = cl;
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      m_ovf = (pu && f && !po) || (m_ovf && !cl);
      m_udf = (po && e) || (m_udf && !cl);
      if (po && !e) void'(q.pop_front());
      if (pu && (!f || po)) q.push_back(d);
      @(posedge clk); #1;
      push_en = 1'b0; pop_en = 1'b0; clr_err = 1'b0; push_data = '0;
      chk_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   initial begin
      rst = 1'b1; push_en = 1'b0; pop_en = 1'b0; clr_err = 1'b0; push_data = '0;
      model_reset();
      #1;
      chk_all("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      cyc("idle", 0, 0, 0, 0);
      chk("idle.head0", head_data, 64'h0);

      // Three pushes then three pops.
      cyc("p1", 1, 64'h1111, 0, 0);
      chk("p1.visible", head_data, 64'h1111);
      cyc("p2", 1, 64'h2222, 0, 0);
      cyc("p3", 1, 64'h3333, 0, 0);
      chk("p3.count", 64'(count), 64'd3);
      cyc("q1", 0, 0, 1, 0);
      chk("q1.head", head_data, 64'h2222);
      cyc("q2", 0, 0, 1, 0);
      chk("q2.head", head_data, 64'h3333);
      cyc("q3", 0, 0, 1, 0);
      chk("q3.head", head_data, 64'h0);

      // Overfill by one.
      for (int i = 0; i < 9; i++) cyc("fill9", 1, 64'(i), 0, 0);
      chk("fill9.ovf", 64'(overflow), 64'd1);
      chk("fill9.full", 64'(full), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("drain8.head", head_data, 64'(i));
         cyc("drain8", 0, 0, 1, 0);
      end
      cyc("clr_ovf", 0, 0, 0, 1);

      // Underflow and set-wins-over-clear.
      cyc("udf", 0, 0, 1, 0);
      chk("udf.flag", 64'(underflow), 64'd1);
      cyc("udf_clr", 0, 0, 0, 1);
      chk("udf_clr.flag", 64'(underflow), 64'd0);
      cyc("udf_setwins", 0, 0, 1, 1);
      chk("udf_setwins.flag", 64'(underflow), 64'd1);
      cyc("udf_clr2", 0, 0, 0, 1);

      // Empty + push + pop: pop rejected, no bypass.
      cyc("e_pp", 1, 64'h5A5A, 1, 0);
      chk("e_pp.count", 64'(count), 64'd1);
      chk("e_pp.udf", 64'(underflow), 64'd1);
      cyc("e_pp_drain", 0, 0, 1, 1);

      // Full + push + pop, then drain across pointer wrap.
      for (int i = 0; i < 8; i++) cyc("wfill", 1, 64'(i), 0, 0);
      cyc("full_pp", 1, 64'hAA, 1, 0);
      chk("full_pp.count", 64'(count), 64'd8);
      chk("full_pp.ovf", 64'(overflow), 64'd0);
      for (int i = 1; i < 8; i++) begin
         chk("wrap.head", head_data, 64'(i));
         cyc("wrap", 0, 0, 1, 0);
      end
      chk("wrap.last", head_data, 64'hAA);
      cyc("wrap_end", 0, 0, 1, 0);

      // Asynchronous reset mid-stream at count 5.
      for (int i = 0; i < 5; i++) cyc("pre_rst", 1, 64'h100 + 64'(i), 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk_all("rst_async");
      @(posedge clk); #1;
      rst = 1'b0;
      chk_all("rst_rel");
      cyc("beef", 1, 64'hBEEF, 0, 0);
      chk("beef.head", head_data, 64'hBEEF);

      // Randomized traffic, alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 800; i++) begin
         int pp;
         bit pu, po, cl;
         pp = ((i / 50) % 2 == 0) ? 70 : 30;
         pu = ($urandom_range(0, 99) < pp);
         po = ($urandom_range(0, 99) < (100 - pp));
         cl = ($urandom_range(0, 99) < 6);
         cyc("rand", pu, {$urandom, $urandom}, po, cl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_fifo.md
# mmio_fifo

Buffering stage fed by the AFU's MMIO write path: every qualified host write to the user register pushes a 64-bit word here. The AFU's MMIO read path consumes the oldest word at the queue head. Circular-buffer FIFO with show-ahead head, occupancy count, and sticky overflow/underflow flags that the AFU exposes as a status CSR.

## Interface
Parameters:
- WIDTH, 64, data word width in bits
- DEPTH, 8, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, count width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- push_en  in  1  write request; samples push_data on the rising edge
- push_data  in  WIDTH  word to enqueue
- pop_en  in  1  remove head entry on the rising edge
- clr_err  in  1  clears overflow/underflow on the rising edge
- head_data  out  WIDTH  oldest entry; forced to 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push attempted while full with no pop
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH array. Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH. count is a separate CW-bit register. Storage array is not reset.
- Push accepted when push_en and (!full or pop_en): write mem[wr_ptr], then wr_ptr+1.
- Pop accepted when pop_en and !empty: rd_ptr+1.
- count next value:
  - +1 on accepted push only
  - −1 on accepted pop only
  - unchanged when both are accepted or neither is
- Full + push + pop: both accepted; count stays DEPTH; no overflow.
- Empty + push + pop: push accepted, pop rejected; count becomes 1; underflow set. No bypass of the new word to head_data in the same cycle.
- Full + push, no pop: word dropped, pointers unchanged, overflow ← 1.
- Empty + pop: no pointer change, underflow ← 1.
- Sticky flags hold until clr_err or rst. If clr_err coincides with a new error event, the flag is set (set wins).
- head_data = mem[rd_ptr] when !empty, else 0. Combinational from registered state only; no path from push_data or pop_en.
- empty and full are decoded from the count register.

## Timing
- Reset values (asynchronous assert; deassert synchronized upstream):
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - empty = 1, full = 0
  - overflow = 0, underflow = 0
  - head_data = 0
- Push-to-visible latency: 1 cycle. A word pushed at edge N into an empty FIFO appears on head_data, with empty=0 and count=1, after edge N.
- Pop effect: head_data advances to the next entry, or goes to 0, after the edge at which the pop is accepted.
- All outputs are stable for the whole cycle and change only on clk edges or async rst.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no gap or duplicate.
- Reset mid-operation: contents are discarded logically (count=0). Stale array data is never visible because head_data is gated by empty.

## Structure
- Package mmio_fifo_pkg holds:
  - localparam MMIO_FIFO_WIDTH = 64 and MMIO_FIFO_DEPTH = 8
  - typedef t_mmio_fifo_status, a packed struct {overflow, underflow, full, empty, count}, which the AFU returns as a CSR word
- Single flat module; no sub-module. The pointer/count logic is too small to justify splitting.
- AFU wiring: push_en = mmio write valid with address 0x0020; pop_en = mmio read valid with address 0x0020.

## Test plan
- Reset, then idle: count=0, empty=1, full=0, head_data=0, both flags 0.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles, then three pops: head_data sequence is 0x1111 → 0x2222 → 0x3333 → 0; count goes 3 → 2 → 1 → 0.
- Push 9 words 0x0..0x8 without popping: full=1 after the 8th; the 9th is dropped and overflow=1; 8 pops return 0x0..0x7.
- Pop while empty: underflow=1, count stays 0. Pulse clr_err: underflow=0. Then pop while empty together with clr_err: underflow remains 1.
- Fill to 8, then push 0xAA and pop together: count stays 8, overflow=0. The next 8 pops yield entries 1..7 then 0xAA, exercising pointer wrap.
- Assert rst mid-stream at count=5: count=0, empty=1, and head_data=0 immediately (async). After release, push 0xBEEF: head_data=0xBEEF after 1 cycle.
